axi4_lite_ram_slave: RTL and testbench

//   AXI4-Lite slave wrapping a word-addressed single-clock RAM with byte strobes.

---
 rtl/axi4_lite_ram_slave.sv | 171 +++++++++++++++++
 tb/tb_axi4_lite_ram_slave.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_ram_slave.sv
// axi4_lite_ram_slave: AXI4-Lite slave over a byte-strobed 32-bit word RAM.
// Independent write and read FSMs, one transaction in flight per direction.
module axi4_lite_ram_slave #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_WIDTH = 10
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        AWVALID,
  input  logic [2:0]  AWPROT,
  input  logic [31:0] AWADDR,
  output logic        AWREADY,
  input  logic        WVALID,
  input  logic [3:0]  WSTRB,
  input  logic [31:0] WDATA,
  output logic        WREADY,
  output logic        BVALID,
  output logic [1:0]  BRESP,
  input  logic        BREADY,
  input  logic        ARVALID,
  input  logic [2:0]  ARPROT,
  input  logic [31:0] ARADDR,
  output logic        ARREADY,
  output logic        RVALID,
  output logic [1:0]  RRESP,
  output logic [31:0] RDATA,
  input  logic        RREADY
);

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_t;

  localparam logic [28:0] WORDS = 29'(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                 aw_held, w_held;
  logic [IDX_WIDTH-1:0] aw_idx, ar_idx;
  logic                 aw_oor, ar_oor;
  logic [31:0]          w_data;
  logic [3:0]           w_strb;
  logic                 aw_fire, w_fire, ar_fire;
  logic                 b_fire, r_fire;
  logic [1:0]           bresp_q, rresp_q;
  logic [31:0]          rdata_q;

  // Protection bits and sub-word / window-select address bits are don't-care.
  logic unused;
  assign unused = ^{AWPROT, ARPROT, AWADDR[31], AWADDR[1:0],
                    ARADDR[31], ARADDR[1:0]};

  assign AWREADY = (w_state == W_IDLE) && !aw_held && !iRST;
  assign WREADY  = (w_state == W_IDLE) && !w_held && !iRST;
  assign BVALID  = (w_state == W_RESP);
  assign BRESP   = bresp_q;
  assign ARREADY = (r_state == R_IDLE) && !iRST;
  assign RVALID  = (r_state == R_DATA);
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign b_fire  = BVALID && BREADY;
  assign ar_fire = ARVALID && ARREADY;
  assign r_fire  = RVALID && RREADY;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: begin
        if ((aw_held || aw_fire) && (w_held || w_fire))
          w_next = W_COMMIT;
      end
      W_COMMIT: w_next = W_RESP;
      W_RESP: begin
        if (b_fire)
          w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: begin
        if (ar_fire)
          r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        if (r_fire)
          r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp_q <= 2'b00;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_idx  <= AWADDR[IDX_WIDTH+1:2];
        aw_oor  <= AWADDR[30:2] >= WORDS;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      if (w_state == W_COMMIT)
        bresp_q <= aw_oor ? 2'b10 : 2'b00;
      if (b_fire) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // RAM port kept reset-free so contents survive reset.
  always_ff @(posedge iCLK) begin
    if (!iRST && w_state == W_COMMIT && !aw_oor) begin
      for (int i = 0; i < 4; i++)
        if (w_strb[i])
          mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else begin
      if (ar_fire) begin
        ar_idx <= ARADDR[IDX_WIDTH+1:2];
        ar_oor <= ARADDR[30:2] >= WORDS;
      end
      if (r_state == R_FETCH) begin
        rdata_q <= ar_oor ? 32'h0 : mem[ar_idx];
        rresp_q <= ar_oor ? 2'b10 : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_ram_slave.sv
// tb_axi4_lite_ram_slave: scenario tasks with scoreboard queues
// for the AXI4-Lite RAM slave.
module tb_axi4_lite_ram_slave;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [2:0]  AWPROT, ARPROT;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;

  int tests = 0;
  int fails = 0;

  logic [33:0] exp_r [$];
  logic [1:0]  exp_b [$];
  logic [31:0] model [int];

  always #5 iCLK = ~iCLK;

  axi4_lite_ram_slave dut (
    .iCLK(iCLK), .iRST(iRST),
    .AWVALID(AWVALID), .AWPROT(AWPROT), .AWADDR(AWADDR), .AWREADY(AWREADY),
    .WVALID(WVALID), .WSTRB(WSTRB), .WDATA(WDATA), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARPROT(ARPROT), .ARADDR(ARADDR), .ARREADY(ARREADY),
    .RVALID(RVALID), .RRESP(RRESP), .RDATA(RDATA), .RREADY(RREADY)
  );

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) old[8*i +: 8] = d[8*i +: 8];
    return old;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp,
                          output bit to);
    bit aw_done, w_done;
    int n;
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = 1'b1; WVALID = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      #1;
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      @(posedge iCLK); #1;
      if (aw_done) AWVALID = 1'b0;
      if (w_done) WVALID = 1'b0;
      n++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    BREADY = 1'b1; n = 0;
    while (!BVALID && n < 50) begin
      @(posedge iCLK); #1;
      n++;
    end
    resp = BRESP;
    to = !(aw_done && w_done && BVALID);
    @(posedge iCLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output bit to);
    bit hs;
    int n;
    ARADDR = a; ARVALID = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 50) begin
      #1;
      if (ARREADY) hs = 1;
      @(posedge iCLK); #1;
      n++;
    end
    ARVALID = 1'b0;
    RREADY = 1'b1; n = 0;
    while (!RVALID && n < 50) begin
      @(posedge iCLK); #1;
      n++;
    end
    d = RDATA; resp = RRESP;
    to = !(hs && RVALID);
    @(posedge iCLK); #1;
    RREADY = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    AWPROT = 0; ARPROT = 0; AWADDR = 0; ARADDR = 0; WDATA = 0; WSTRB = 0;
    repeat (3) @(posedge iCLK);
    #1;
    tests++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    tests++;
    if ({BRESP, RRESP, RDATA} !== 36'h0) begin
      fails++;
      $display("FAIL reset_payload: got %h expected 0", {BRESP, RRESP, RDATA});
    end
    iRST = 1'b0;
    #1;
    tests++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      fails++;
      $display("FAIL reset_release_ready: got %b expected 111",
               {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_write_read();
    logic [1:0]  eb;
    logic [33:0] er;
    AWADDR = 32'h8000_0010; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1; BREADY = 1;
    exp_b.push_back(2'b00);
    model[4] = 32'hDEAD_BEEF;
    @(posedge iCLK); #1;
    AWVALID = 0; WVALID = 0;
    tests++;
    if (BVALID !== 1'b0) begin
      fails++;
      $display("FAIL b_latency_early: BVALID got %b expected 0", BVALID);
    end
    @(posedge iCLK); #1;
    eb = exp_b.pop_front();
    tests++;
    if ({BVALID, BRESP} !== {1'b1, eb}) begin
      fails++;
      $display("FAIL b_latency: got %b expected %b", {BVALID, BRESP}, {1'b1, eb});
    end
    @(posedge iCLK); #1;
    BREADY = 0;
    ARADDR = 32'h8000_0010; ARVALID = 1; RREADY = 0;
    exp_r.push_back({2'b00, 32'hDEAD_BEEF});
    @(posedge iCLK); #1;
    ARVALID = 0;
    tests++;
    if (RVALID !== 1'b0) begin
      fails++;
      $display("FAIL r_latency_early: RVALID got %b expected 0", RVALID);
    end
    @(posedge iCLK); #1;
    er = exp_r.pop_front();
    tests++;
    if ({RVALID, RRESP, RDATA} !== {1'b1, er}) begin
      fails++;
      $display("FAIL basic_read: got %h expected %h",
               {RVALID, RRESP, RDATA}, {1'b1, er});
    end
    RREADY = 1;
    @(posedge iCLK); #1;
    RREADY = 0;
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] er;
    bit          to;
    int          n;
    WDATA = 32'h1122_3344; WSTRB = 4'b0101; WVALID = 1;
    model[4] = merge(model[4], 32'h1122_3344, 4'b0101);
    exp_r.push_back({2'b00, 32'hDE22_BE44});
    #1;
    tests++;
    if (WREADY !== 1'b1) begin
      fails++;
      $display("FAIL w_first_ready: WREADY got %b expected 1", WREADY);
    end
    @(posedge iCLK); #1;
    WVALID = 0;
    repeat (2) @(posedge iCLK);
    #1;
    tests++;
    if ({WREADY, AWREADY, BVALID} !== 3'b010) begin
      fails++;
      $display("FAIL w_held: got %b expected 010", {WREADY, AWREADY, BVALID});
    end
    AWADDR = 32'h0000_0010; AWVALID = 1; BREADY = 1;
    @(posedge iCLK); #1;
    AWVALID = 0;
    n = 0;
    while (!BVALID && n < 20) begin
      @(posedge iCLK); #1;
      n++;
    end
    tests++;
    if ({BVALID, BRESP} !== 3'b100) begin
      fails++;
      $display("FAIL w_first_resp: got %b expected 100", {BVALID, BRESP});
    end
    @(posedge iCLK); #1;
    BREADY = 0;
    do_read(32'h10, d, r, to);
    er = exp_r.pop_front();
    tests++;
    if (to || {r, d} !== er) begin
      fails++;
      $display("FAIL strobe_merge: got %h to=%0b expected %h", {r, d}, to, er);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    logic [1:0]  r, eb;
    logic [33:0] er;
    bit          to;
    do_write(32'h0, 32'hCAFE_F00D, 4'hF, r, to);
    model[0] = 32'hCAFE_F00D;
    do_write(32'hFFC, 32'hA5A5_0001, 4'hF, r, to);
    model[1023] = 32'hA5A5_0001;
    tests++;
    if (to || r !== 2'b00) begin
      fails++;
      $display("FAIL last_word_write: got %b to=%0b expected 00", r, to);
    end
    exp_r.push_back({2'b10, 32'h0});
    do_read(32'h1000, d, r, to);
    er = exp_r.pop_front();
    tests++;
    if (to || {r, d} !== er) begin
      fails++;
      $display("FAIL oor_read: got %h to=%0b expected %h", {r, d}, to, er);
    end
    exp_b.push_back(2'b10);
    do_write(32'h1000, 32'h1234_5678, 4'hF, r, to);
    eb = exp_b.pop_front();
    tests++;
    if (to || r !== eb) begin
      fails++;
      $display("FAIL oor_write: got %b to=%0b expected %b", r, to, eb);
    end
    exp_r.push_back({2'b00, model[0]});
    do_read(32'h0, d, r, to);
    er = exp_r.pop_front();
    tests++;
    if (to || {r, d} !== er) begin
      fails++;
      $display("FAIL oor_no_alias: got %h to=%0b expected %h", {r, d}, to, er);
    end
    exp_r.push_back({2'b00, model[1023]});
    do_read(32'h8000_0FFC, d, r, to);
    er = exp_r.pop_front();
    tests++;
    if (to || {r, d} !== er) begin
      fails++;
      $display("FAIL last_word_read: got %h to=%0b expected %h", {r, d}, to, er);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  eb;
    logic [33:0] er;
    AWADDR = 32'h20; WDATA = 32'h0BAD_C0DE; WSTRB = 4'hF;
    ARADDR = 32'h10;
    AWVALID = 1; WVALID = 1; ARVALID = 1; BREADY = 0; RREADY = 0;
    model[8] = 32'h0BAD_C0DE;
    exp_b.push_back(2'b00);
    exp_r.push_back({2'b00, model[4]});
    @(posedge iCLK); #1;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    @(posedge iCLK); #1;
    eb = exp_b.pop_front();
    er = exp_r.pop_front();
    for (int c = 0; c < 5; c++) begin
      tests++;
      if ({BVALID, RVALID, BRESP, RRESP, RDATA, AWREADY, WREADY, ARREADY}
          !== {1'b1, 1'b1, eb, er, 3'b000}) begin
        fails++;
        $display("FAIL stall_cycle%0d: got %h expected %h", c,
                 {BVALID, RVALID, BRESP, RRESP, RDATA, AWREADY, WREADY, ARREADY},
                 {1'b1, 1'b1, eb, er, 3'b000});
      end
      AWVALID = (c > 2); ARVALID = (c > 2);
      @(posedge iCLK); #1;
    end
    AWVALID = 0; ARVALID = 0;
    BREADY = 1; RREADY = 1;
    @(posedge iCLK); #1;
    BREADY = 0; RREADY = 0;
    tests++;
    if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b00111) begin
      fails++;
      $display("FAIL stall_release: got %b expected 00111",
               {BVALID, RVALID, AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    logic [1:0]  r, eb;
    logic [33:0] er;
    bit          to;
    AWADDR = 32'h10; WDATA = 32'h55AA_55AA; WSTRB = 4'hF; ARADDR = 32'h10;
    AWVALID = 1; WVALID = 1; ARVALID = 1; BREADY = 0; RREADY = 0;
    exp_r.push_back({2'b00, model[4]});
    exp_b.push_back(2'b00);
    model[4] = 32'h55AA_55AA;
    @(posedge iCLK); #1;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    @(posedge iCLK); #1;
    er = exp_r.pop_front();
    eb = exp_b.pop_front();
    tests++;
    if ({RVALID, RRESP, RDATA, BVALID, BRESP} !== {1'b1, er, 1'b1, eb}) begin
      fails++;
      $display("FAIL rbw_old: got %h expected %h",
               {RVALID, RRESP, RDATA, BVALID, BRESP}, {1'b1, er, 1'b1, eb});
    end
    BREADY = 1; RREADY = 1;
    @(posedge iCLK); #1;
    BREADY = 0; RREADY = 0;
    exp_r.push_back({2'b00, model[4]});
    do_read(32'h10, d, r, to);
    er = exp_r.pop_front();
    tests++;
    if (to || {r, d} !== er) begin
      fails++;
      $display("FAIL rbw_new: got %h to=%0b expected %h", {r, d}, to, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ar_seq, rv_seq;
    logic [31:0] d2;
    ARADDR = 32'h20; ARVALID = 1; RREADY = 1;
    d2 = 32'h0;
    for (int c = 0; c < 4; c++) begin
      #1;
      ar_seq[c] = ARREADY;
      rv_seq[c] = RVALID;
      if (c == 2) d2 = RDATA;
      if (c == 3) ARVALID = 0;
      @(posedge iCLK); #1;
    end
    ARVALID = 0; RREADY = 0;
    tests++;
    if ({ar_seq, rv_seq} !== {4'b1001, 4'b0100}) begin
      fails++;
      $display("FAIL b2b_seq: got ar=%b rv=%b expected ar=1001 rv=0100",
               ar_seq, rv_seq);
    end
    tests++;
    if (d2 !== model[8]) begin
      fails++;
      $display("FAIL b2b_data: got %h expected %h", d2, model[8]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] er;
    bit          to;
    ARADDR = 32'h10; ARVALID = 1; RREADY = 0; BREADY = 0;
    @(posedge iCLK); #1;
    ARVALID = 0;
    AWADDR = 32'h20; WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1;
    @(posedge iCLK); #1;
    AWVALID = 0; WVALID = 0;
    iRST = 1;
    #1;
    tests++;
    if ({AWREADY, WREADY, ARREADY, RVALID} !== 4'b0001) begin
      fails++;
      $display("FAIL mid_rst_ready: got %b expected 0001",
               {AWREADY, WREADY, ARREADY, RVALID});
    end
    @(posedge iCLK); #1;
    tests++;
    if ({BVALID, RVALID, BRESP, RRESP, RDATA} !== 38'h0) begin
      fails++;
      $display("FAIL mid_rst_clear: got %h expected 0",
               {BVALID, RVALID, BRESP, RRESP, RDATA});
    end
    iRST = 0;
    exp_r.push_back({2'b00, model[8]});
    do_read(32'h20, d, r, to);
    er = exp_r.pop_front();
    tests++;
    if (to || {r, d} !== er) begin
      fails++;
      $display("FAIL mid_rst_nowrite: got %h to=%0b expected %h", {r, d}, to, er);
    end
    do_write(32'h24, 32'h600D_F00D, 4'b1100, r, to);
    model[9] = merge(32'h0, 32'h600D_F00D, 4'b1100);
    tests++;
    if (to || r !== 2'b00) begin
      fails++;
      $display("FAIL post_rst_write: got %b to=%0b expected 00", r, to);
    end
    do_write(32'h24, 32'h0, 4'b0011, r, to);
    exp_r.push_back({2'b00, model[9]});
    do_read(32'h24, d, r, to);
    er = exp_r.pop_front();
    tests++;
    if (to || {r, d} !== er) begin
      fails++;
      $display("FAIL post_rst_read: got %h to=%0b expected %h", {r, d}, to, er);
    end
  endtask

  task automatic test_zero_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] er;
    bit          to;
    do_write(32'h24, 32'hFFFF_FFFF, 4'b0000, r, to);
    tests++;
    if (to || r !== 2'b00) begin
      fails++;
      $display("FAIL zero_strb_resp: got %b to=%0b expected 00", r, to);
    end
    exp_r.push_back({2'b00, model[9]});
    do_read(32'h24, d, r, to);
    er = exp_r.pop_front();
    tests++;
    if (to || {r, d} !== er) begin
      fails++;
      $display("FAIL zero_strb_data: got %h to=%0b expected %h", {r, d}, to, er);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_zero_strobe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
